// File: rtl/me_block_loader.sv
// me_block_loader: packs an 8-bit pixel stream into 64-bit words for the motion-estimation engine's
// cur/ref write ports, starts the search, and hands the motion vector downstream. Option: ME_SOB_RESYNC_EN.
module me_block_loader #(
  parameter  int CUR_DIM   = 16,
  parameter  int REF_DIM   = 32,
  parameter  int PIX_W     = 8,
  localparam int WORD_W    = 8 * PIX_W,
  localparam int CUR_WORDS = CUR_DIM * CUR_DIM / 8,
  localparam int REF_WORDS = REF_DIM * REF_DIM / 8,
  localparam int CUR_AW    = $clog2(CUR_WORDS),
  localparam int REF_AW    = $clog2(REF_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PIX_W-1:0]  pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [CUR_AW-1:0] address_write_cur,
  output logic [WORD_W-1:0] data_write_cur,
  output logic              write_enable_cur,
  output logic [REF_AW-1:0] address_write_ref,
  output logic [WORD_W-1:0] data_write_ref,
  output logic              write_enable_ref,
  output logic              go,
  input  logic              done,
  input  logic [7:0]        m_i,
  input  logic [7:0]        m_j,
  output logic [7:0]        mv_i,
  output logic [7:0]        mv_j,
  output logic              mv_valid,
`ifdef ME_SOB_RESYNC_EN
  input  logic              pix_sob,
`endif
  input  logic              mv_ready
);

  localparam int CNT_W  = (REF_AW > CUR_AW) ? REF_AW : CUR_AW;
  localparam int SLOT_W = 3;

  typedef enum logic [1:0] {LOAD_CUR, LOAD_REF, RUN, OUT} state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] acc_p0;
  logic [SLOT_W-1:0] slot_p0;
  logic [CNT_W-1:0]  word_cnt_p0;
  logic              done_q;

  logic xfer, sob, word_end, cur_last, ref_last, capture, mv_take;

  assign pix_ready = (state == LOAD_CUR) || (state == LOAD_REF);
  assign xfer      = pix_valid && pix_ready;
`ifdef ME_SOB_RESYNC_EN
  assign sob       = xfer && pix_sob;
`else
  assign sob       = 1'b0;
`endif
  // A resync pixel always starts a fresh word, so it can never complete one.
  assign word_end  = xfer && !sob && (slot_p0 == SLOT_W'(7));
  assign cur_last  = word_end && (state == LOAD_CUR) && (word_cnt_p0 == CNT_W'(CUR_WORDS - 1));
  assign ref_last  = word_end && (state == LOAD_REF) && (word_cnt_p0 == CNT_W'(REF_WORDS - 1));
  assign capture   = (state == RUN) && done && !done_q;
  assign mv_take   = mv_valid && mv_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD_CUR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_CUR: if (cur_last) state_nxt = LOAD_REF;
      LOAD_REF: begin
        if (sob)           state_nxt = LOAD_CUR;
        else if (ref_last) state_nxt = RUN;
      end
      RUN:      if (capture) state_nxt = OUT;
      OUT:      if (mv_take) state_nxt = LOAD_CUR;
      default:  state_nxt = LOAD_CUR;
    endcase
  end

  // p0: pixel accumulation; completed word is registered onto the write port one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_p0            <= '0;
      slot_p0           <= '0;
      word_cnt_p0       <= '0;
      done_q            <= 1'b0;
      go                <= 1'b0;
      mv_valid          <= 1'b0;
      mv_i              <= '0;
      mv_j              <= '0;
      write_enable_cur  <= 1'b0;
      write_enable_ref  <= 1'b0;
      address_write_cur <= '0;
      address_write_ref <= '0;
      data_write_cur    <= '0;
      data_write_ref    <= '0;
    end else begin
      done_q           <= done;
      write_enable_cur <= 1'b0;
      write_enable_ref <= 1'b0;
      // go rises one cycle after the final ref write and drops with the capture
      go               <= (state == RUN) && (state_nxt == RUN);

      if (xfer) begin
        acc_p0 <= {pix_in, acc_p0[WORD_W-1:PIX_W]};
        if (sob) begin
          slot_p0     <= SLOT_W'(1);
          word_cnt_p0 <= '0;
        end else if (word_end) begin
          slot_p0 <= '0;
          if (state == LOAD_CUR) begin
            data_write_cur    <= {pix_in, acc_p0[WORD_W-1:PIX_W]};
            address_write_cur <= word_cnt_p0[CUR_AW-1:0];
            write_enable_cur  <= 1'b1;
            word_cnt_p0       <= cur_last ? '0 : word_cnt_p0 + CNT_W'(1);
          end else begin
            data_write_ref    <= {pix_in, acc_p0[WORD_W-1:PIX_W]};
            address_write_ref <= word_cnt_p0[REF_AW-1:0];
            write_enable_ref  <= 1'b1;
            word_cnt_p0       <= ref_last ? '0 : word_cnt_p0 + CNT_W'(1);
          end
        end else begin
          slot_p0 <= slot_p0 + SLOT_W'(1);
        end
      end

      if (capture) begin
        mv_i     <= m_i;
        mv_j     <= m_j;
        mv_valid <= 1'b1;
      end else if (mv_take) begin
        mv_valid    <= 1'b0;
        slot_p0     <= '0;
        word_cnt_p0 <= '0;
      end
    end
  end

endmodule
